// File: rtl/tpu_pkg.sv
// Shared types and MMIO map for the TPU MMIO front-end.
package tpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_FEED  = 2'd2
  } state_t;

  localparam int unsigned A_OFS      = 32'h0100;
  localparam int unsigned B_OFS      = 32'h0200;
  localparam int unsigned C_OFS      = 32'h0300;
  localparam int unsigned CTRL_OFS   = 32'h0400;
  localparam int unsigned STATUS_OFS = 32'h0500;
  localparam int unsigned PERF_OFS   = 32'h0508;

  localparam int CTRL_START = 0;
  localparam int CTRL_ACC   = 1;
  localparam int STAT_BUSY  = 0;
  localparam int STAT_DONE  = 1;

endpackage

// File: rtl/tpu_skew_feed.sv
// DIM x DIM operand buffer with diagonal (wavefront) readout at a given step.
// ROW_FEED=1: lane l = buf[l][step-l] (A side); ROW_FEED=0: lane l = buf[step-l][l] (B side).
module tpu_skew_feed #(
  parameter int BITS     = 8,
  parameter int DIM      = 8,
  parameter int STW      = 5,
  parameter bit ROW_FEED = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [$clog2(DIM)-1:0]  wr_row,
  input  logic [DIM*BITS-1:0]     wr_data,
  input  logic                    en,
  input  logic [STW-1:0]          step,
  output logic [DIM*BITS-1:0]     feed
);

  localparam int RW = $clog2(DIM);

  logic [DIM*BITS-1:0] buf_q [DIM];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DIM; r++) buf_q[r] <= '0;
    end else if (wr_en) begin
      buf_q[wr_row] <= wr_data;
    end
  end

  // Lanes outside the active diagonal band are driven to zero.
  always_comb begin
    feed = '0;
    for (int l = 0; l < DIM; l++) begin
      if (en && (int'(step) >= l) && (int'(step) - l < DIM)) begin
        if (ROW_FEED)
          feed[l*BITS +: BITS] = buf_q[l][(int'(step) - l)*BITS +: BITS];
        else
          feed[l*BITS +: BITS] = buf_q[RW'(int'(step) - l)][l*BITS +: BITS];
      end
    end
  end

endmodule

// File: rtl/tpu_mmio_ctrl.sv
// MMIO front-end for a DIM x DIM output-stationary systolic array.
// Optional busy-cycle counter at PERF enabled by defining TPU_PERF_CNT_EN.
//
// state    | meaning
// ST_IDLE  | operands/C accessible over MMIO, waiting for start
// ST_CLEAR | zeroing C rows 0..DIM-1, one per cycle
// ST_FEED  | streaming skewed A/B into the array, 3*DIM-2 steps
module tpu_mmio_ctrl
  import tpu_pkg::*;
#(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16,
  parameter int DIM     = 8,
  parameter int ADDRW   = 16,
  parameter int DATAW   = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req,
  input  logic                    r_w,
  input  logic [ADDRW-1:0]        addr,
  input  logic [DATAW-1:0]        dataIn,
  output logic [DATAW-1:0]        dataOut,
  output logic                    busy,
  output logic                    done_pulse,
  output logic                    arr_en,
  output logic [DIM*BITS_AB-1:0]  arr_a,
  output logic [DIM*BITS_AB-1:0]  arr_b,
  output logic                    arr_c_wr,
  output logic [$clog2(DIM)-1:0]  arr_c_row,
  output logic [DIM*BITS_C-1:0]   arr_cin,
  input  logic [DIM*BITS_C-1:0]   arr_cout
);

  localparam int CW  = DIM*BITS_C/DATAW;
  localparam int CWW = (CW > 1) ? $clog2(CW) : 1;
  localparam int SW  = (CW > 1) ? CW - 1 : 1;
  localparam int RW  = $clog2(DIM);
  localparam int STW = $clog2(3*DIM);

  localparam logic [ADDRW-1:0] A_LO      = ADDRW'(A_OFS);
  localparam logic [ADDRW-1:0] B_LO      = ADDRW'(B_OFS);
  localparam logic [ADDRW-1:0] C_LO      = ADDRW'(C_OFS);
  localparam logic [ADDRW-1:0] CTRL_LO   = ADDRW'(CTRL_OFS);
  localparam logic [ADDRW-1:0] STATUS_LO = ADDRW'(STATUS_OFS);
  localparam logic [ADDRW-1:0] PERF_LO   = ADDRW'(PERF_OFS);
  localparam logic [ADDRW-1:0] AB_SPAN   = ADDRW'(8*DIM);
  localparam logic [ADDRW-1:0] C_SPAN    = ADDRW'(8*DIM*CW);

  localparam logic [STW-1:0] FEED_LAST  = STW'(3*DIM - 3);
  localparam logic [STW-1:0] CLEAR_LAST = STW'(DIM - 1);
  localparam logic [CWW-1:0] C_LAST     = CWW'(CW - 1);

  state_t            state_q;
  logic [STW-1:0]    cnt_q;
  logic              done_q;
  logic [DATAW-1:0]  staging_q [SW];

  logic              aligned, hit_a, hit_b, hit_c, hit_ctrl, hit_status, hit_perf;
  logic [ADDRW-1:0]  a_off, b_off, c_off, c_idx;
  logic [RW-1:0]     a_row, b_row, c_row, clr_row, row_sel;
  logic [CWW-1:0]    c_word;
  logic              wr, idle, clearing, feeding, start, c_commit, stage_wr;
  logic [STW-1:0]    step;
  logic [DATAW-1:0]  rd_data, perf_val;
  logic [DIM*BITS_C-1:0] cin_wr;

  // Offsets below a base wrap to large values, so one compare bounds each window.
  always_comb begin
    aligned    = (addr[2:0] == 3'b000);
    a_off      = addr - A_LO;
    b_off      = addr - B_LO;
    c_off      = addr - C_LO;
    c_idx      = c_off >> 3;
    hit_a      = aligned && (a_off < AB_SPAN);
    hit_b      = aligned && (b_off < AB_SPAN);
    hit_c      = aligned && (c_off < C_SPAN);
    hit_ctrl   = (addr == CTRL_LO);
    hit_status = (addr == STATUS_LO);
    hit_perf   = (addr == PERF_LO);
    a_row      = a_off[3 +: RW];
    b_row      = b_off[3 +: RW];
    c_row      = RW'(c_idx / ADDRW'(CW));
    c_word     = CWW'(c_idx % ADDRW'(CW));
  end

  assign wr       = req && r_w;
  assign idle     = (state_q == ST_IDLE);
  assign clearing = (state_q == ST_CLEAR);
  assign feeding  = (state_q == ST_FEED);
  assign start    = wr && idle && hit_ctrl && dataIn[CTRL_START];
  assign c_commit = wr && idle && hit_c && (c_word == C_LAST);
  assign stage_wr = wr && idle && hit_c && (c_word != C_LAST);
  assign step     = FEED_LAST - cnt_q;
  assign clr_row  = RW'(CLEAR_LAST - cnt_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            done_q <= 1'b0;
            if (dataIn[CTRL_ACC]) begin
              state_q <= ST_FEED;
              cnt_q   <= FEED_LAST;
            end else begin
              state_q <= ST_CLEAR;
              cnt_q   <= CLEAR_LAST;
            end
          end
        end
        ST_CLEAR: begin
          if (cnt_q == '0) begin
            state_q <= ST_FEED;
            cnt_q   <= FEED_LAST;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_FEED: begin
          if (cnt_q == '0) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < SW; w++) staging_q[w] <= '0;
    end else begin
      for (int w = 0; w < SW; w++)
        if (stage_wr && (c_word == CWW'(w))) staging_q[w] <= dataIn;
    end
  end

  always_comb begin
    cin_wr = '0;
    for (int w = 0; w < SW; w++) cin_wr[w*DATAW +: DATAW] = staging_q[w];
    cin_wr[(CW-1)*DATAW +: DATAW] = dataIn;
  end

  tpu_skew_feed #(.BITS(BITS_AB), .DIM(DIM), .STW(STW), .ROW_FEED(1'b1)) u_feed_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr && idle && hit_a), .wr_row(a_row),
    .wr_data(dataIn), .en(feeding), .step(step), .feed(arr_a)
  );

  tpu_skew_feed #(.BITS(BITS_AB), .DIM(DIM), .STW(STW), .ROW_FEED(1'b0)) u_feed_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr && idle && hit_b), .wr_row(b_row),
    .wr_data(dataIn), .en(feeding), .step(step), .feed(arr_b)
  );

`ifdef TPU_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              perf_q <= '0;
    else if (wr && hit_perf) perf_q <= '0;
    else if (busy)           perf_q <= perf_q + 32'd1;
  end

  assign perf_val = DATAW'(perf_q);
`else
  assign perf_val = '0;
`endif

  always_comb begin
    rd_data = '0;
    if (hit_c && idle) begin
      rd_data = arr_cout[c_word*DATAW +: DATAW];
    end else if (hit_status) begin
      rd_data[STAT_BUSY] = busy;
      rd_data[STAT_DONE] = done_q;
    end else if (hit_perf) begin
      rd_data = perf_val;
    end
  end

  always_comb begin
    row_sel = '0;
    if (clearing)           row_sel = clr_row;
    else if (idle && hit_c) row_sel = c_row;
  end

  // Address-driven outputs are held quiet while reset is asserted.
  assign dataOut    = rst_n ? rd_data : '0;
  assign arr_c_row  = rst_n ? row_sel : '0;
  assign arr_c_wr   = rst_n && (clearing || c_commit);
  assign arr_cin    = (rst_n && c_commit) ? cin_wr : '0;
  assign busy       = !idle;
  assign arr_en     = feeding;
  assign done_pulse = feeding && (cnt_q == '0);

endmodule
